// File: rtl/vga_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_if
//
// Purpose: bundles the raster timing outputs of vga_timing_gen so a display
// pipeline can take them as a single port.
//
// Signals:
//   hsync, vsync       sync pulses at the generator's configured polarity
//   vga_blank_n        high only while the current pixel is visible
//   vga_clk            pixel clock for the DAC
//   hcount, vcount     current pixel / line position (CW bits)
//   line_start         one-clk pulse when hcount wraps to 0
//   frame_start        one-clk pulse when (hcount,vcount) wraps to (0,0)
//   fetch_valid        pixel prefetch request is for a visible pixel
//   fetch_x, fetch_y   coordinates of the pixel being prefetched
//
// Modports:
//   master  the timing generator (drives everything)
//   slave   a consumer of the timing (reads everything)
// -----------------------------------------------------------------------------
interface vga_timing_gen_if #(
  parameter int CW = 11
);

  logic          hsync;
  logic          vsync;
  logic          vga_blank_n;
  logic          vga_clk;
  logic [CW-1:0] hcount;
  logic [CW-1:0] vcount;
  logic          line_start;
  logic          frame_start;
  logic          fetch_valid;
  logic [CW-1:0] fetch_x;
  logic [CW-1:0] fetch_y;

  modport master (
    output hsync,
    output vsync,
    output vga_blank_n,
    output vga_clk,
    output hcount,
    output vcount,
    output line_start,
    output frame_start,
    output fetch_valid,
    output fetch_x,
    output fetch_y
  );

  modport slave (
    input hsync,
    input vsync,
    input vga_blank_n,
    input vga_clk,
    input hcount,
    input vcount,
    input line_start,
    input frame_start,
    input fetch_valid,
    input fetch_x,
    input fetch_y
  );

endinterface

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Purpose: generates VGA raster timing from a system clock. A divider
// produces one pixel tick every CLK_DIV system clocks; horizontal and
// vertical counters step on that tick. Sync, blanking, line/frame pulses and
// a pixel prefetch request are registered so they line up exactly with the
// counters.
//
// Ports:
//   clk   input   system clock, all state on its rising edge
//   rst   input   asynchronous active-low reset
//   en    input   timing enable; low holds everything cleared at (0,0)
//   vid   master  timing outputs (see vga_timing_gen_if)
//
// Parameters: H_/V_ ACTIVE, FP, SYNC, BP region sizes; HS_POL / VS_POL sync
// active levels; CLK_DIV system clocks per pixel (even, >= 2); LOOKAHEAD
// prefetch lead in pixels (1 .. H_FP+H_SYNC+H_BP); CW counter width, which
// must hold H_TOTAL and V_TOTAL.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HS_POL    = 0,
  parameter int VS_POL    = 0,
  parameter int CLK_DIV   = 2,
  parameter int LOOKAHEAD = 2,
  parameter int CW        = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  vga_timing_gen_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = $clog2(CLK_DIV);

  // Region boundaries sized to the counter width so every compare is
  // width-matched.
  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END     = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END     = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] LA_STEP    = CW'(LOOKAHEAD);
  // Positions at or beyond this point look ahead into the next line.
  localparam logic [CW-1:0] LA_WRAP    = CW'(H_TOTAL - LOOKAHEAD);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF   = DW'(CLK_DIV / 2);
  localparam logic [DW-1:0] DIV_ONE    = DW'(1);

  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  // Registered state
  logic [DW-1:0] div_cnt;
  logic [CW-1:0] hcount_q;
  logic [CW-1:0] vcount_q;
  logic          vga_clk_q;
  logic          hsync_q;
  logic          vsync_q;
  logic          blank_n_q;
  logic          line_start_q;
  logic          frame_start_q;
  logic          fetch_valid_q;
  logic [CW-1:0] fetch_x_q;
  logic [CW-1:0] fetch_y_q;

  // Next-state and decode
  logic          pix_en;
  logic [DW-1:0] div_next;
  logic          h_wrap;
  logic          v_wrap;
  logic [CW-1:0] h_next;
  logic [CW-1:0] v_next;
  logic          line_start_next;
  logic          frame_start_next;
  logic          hs_act;
  logic          vs_act;
  logic          visible;
  logic [CW-1:0] fx;
  logic [CW-1:0] fy;
  logic          f_vis;

  assign pix_en = en && (div_cnt == DIV_LAST);

  // Divider: free-runs 0..CLK_DIV-1 while enabled, parked at 0 otherwise,
  // so the first pixel tick after enable comes a full CLK_DIV clocks later.
  always_comb begin
    div_next = div_cnt;
    if (!en) begin
      div_next = '0;
    end else if (div_cnt == DIV_LAST) begin
      div_next = '0;
    end else begin
      div_next = div_cnt + DIV_ONE;
    end
  end

  // Raster counters' next state. Disabling clears them directly rather
  // than through a wrap, so no line/frame pulse comes out of an enable edge.
  always_comb begin
    h_wrap           = (hcount_q == H_LAST);
    v_wrap           = (vcount_q == V_LAST);
    h_next           = hcount_q;
    v_next           = vcount_q;
    line_start_next  = 1'b0;
    frame_start_next = 1'b0;
    if (!en) begin
      h_next = '0;
      v_next = '0;
    end else if (pix_en) begin
      if (h_wrap) begin
        h_next          = '0;
        v_next          = v_wrap ? '0 : (vcount_q + CNT_ONE);
        line_start_next = 1'b1;
        frame_start_next = v_wrap;
      end else begin
        h_next = hcount_q + CNT_ONE;
      end
    end
  end

  // Output decode works on the next-state counters; registering the result
  // makes sync/blank/fetch change on the same edge as hcount/vcount.
  always_comb begin
    hs_act  = (h_next >= HS_START) && (h_next < HS_END);
    vs_act  = (v_next >= VS_START) && (v_next < VS_END);
    visible = (h_next < H_ACT_END) && (v_next < V_ACT_END);

    // Pixel LOOKAHEAD ticks ahead; LOOKAHEAD never exceeds the horizontal
    // blanking width, so at most one line wrap is possible.
    if (h_next >= LA_WRAP) begin
      fx = h_next - LA_WRAP;
      fy = (v_next == V_LAST) ? '0 : (v_next + CNT_ONE);
    end else begin
      fx = h_next + LA_STEP;
      fy = v_next;
    end
    f_vis = (fx < H_ACT_END) && (fy < V_ACT_END);
  end

  // All state. vga_clk is the divider phase registered, giving a 50% duty
  // cycle whose rising edge lands inside the pixel. fetch_x/fetch_y only
  // load on a valid request and otherwise keep the last requested pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt       <= '0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      vga_clk_q     <= 1'b0;
      hsync_q       <= ~HS_ON;
      vsync_q       <= ~VS_ON;
      blank_n_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_x_q     <= '0;
      fetch_y_q     <= '0;
    end else begin
      div_cnt       <= div_next;
      hcount_q      <= h_next;
      vcount_q      <= v_next;
      vga_clk_q     <= en && (div_cnt >= DIV_HALF);
      hsync_q       <= (en && hs_act) ? HS_ON : ~HS_ON;
      vsync_q       <= (en && vs_act) ? VS_ON : ~VS_ON;
      blank_n_q     <= en && visible;
      line_start_q  <= line_start_next;
      frame_start_q <= frame_start_next;
      fetch_valid_q <= en && f_vis;
      if (en && f_vis) begin
        fetch_x_q <= fx;
        fetch_y_q <= fy;
      end
    end
  end

  assign vid.hsync       = hsync_q;
  assign vid.vsync       = vsync_q;
  assign vid.vga_blank_n = blank_n_q;
  assign vid.vga_clk     = vga_clk_q;
  assign vid.hcount      = hcount_q;
  assign vid.vcount      = vcount_q;
  assign vid.line_start  = line_start_q;
  assign vid.frame_start = frame_start_q;
  assign vid.fetch_valid = fetch_valid_q;
  assign vid.fetch_x     = fetch_x_q;
  assign vid.fetch_y     = fetch_y_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Purpose: self-checking bench for vga_timing_gen. dut_a uses the default
// 640x480 timing (CLK_DIV=2); dut_b uses a tiny 8x4 raster (H 8/2/3/3,
// V 4/1/1/1, CLK_DIV=4, HS_POL=1) so whole frames fit in a short run.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_a;
  logic en_a;
  logic rst_b;
  logic en_b;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.CW(11)) vid_a ();
  vga_timing_gen_if #(.CW(11)) vid_b ();

  vga_timing_gen dut_a (
    .clk (clk),
    .rst (rst_a),
    .en  (en_a),
    .vid (vid_a)
  );

  vga_timing_gen #(
    .H_ACTIVE (8),
    .H_FP     (2),
    .H_SYNC   (3),
    .H_BP     (3),
    .V_ACTIVE (4),
    .V_FP     (1),
    .V_SYNC   (1),
    .V_BP     (1),
    .HS_POL   (1),
    .VS_POL   (0),
    .CLK_DIV  (4),
    .LOOKAHEAD(2),
    .CW       (11)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .en  (en_b),
    .vid (vid_b)
  );

  int check_count = 0;
  int pass_count  = 0;
  int edge_b      = 0;

  // One vector: system-clock edge count after dut_b reset release, then the
  // expected outputs sampled 1 time unit after that edge.
  typedef struct {
    int edge_no;
    int hc, vc;
    int hs, vs, blank, vclk, ls, fs, fv, fx, fy;
  } vec_t;

  vec_t vecs [18];

  function automatic void check_val(input string name, input int actual, input int expected);
    check_count++;
    if (actual == expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int target_edge);
    if (target_edge > edge_b) tick(target_edge - edge_b);
    edge_b = target_edge;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    check_val($sformatf("vec%0d hcount", idx),      int'(vid_b.hcount),      v.hc);
    check_val($sformatf("vec%0d vcount", idx),      int'(vid_b.vcount),      v.vc);
    check_val($sformatf("vec%0d hsync", idx),       int'(vid_b.hsync),       v.hs);
    check_val($sformatf("vec%0d vsync", idx),       int'(vid_b.vsync),       v.vs);
    check_val($sformatf("vec%0d blank_n", idx),     int'(vid_b.vga_blank_n), v.blank);
    check_val($sformatf("vec%0d vga_clk", idx),     int'(vid_b.vga_clk),     v.vclk);
    check_val($sformatf("vec%0d line_start", idx),  int'(vid_b.line_start),  v.ls);
    check_val($sformatf("vec%0d frame_start", idx), int'(vid_b.frame_start), v.fs);
    check_val($sformatf("vec%0d fetch_valid", idx), int'(vid_b.fetch_valid), v.fv);
    check_val($sformatf("vec%0d fetch_x", idx),     int'(vid_b.fetch_x),     v.fx);
    check_val($sformatf("vec%0d fetch_y", idx),     int'(vid_b.fetch_y),     v.fy);
  endtask

  // Timeout guard so the run always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int h, v, fxe, fye, fve, hse, ble, lse;
    int hc_err, vc_err, hs_err, vs_err, bl_err, fv_err, fxy_err, ls_err, fs_err, vclk_err;
    int low_cnt, first_low, last_low, blank_cnt0;
    int blank_cnt, hs_cnt, vs_cnt, ls_cnt, frame_clks, seen;

    //                edge  hc vc  hs vs bl vck ls fs  fv fx fy
    vecs[0]  = '{   1,  0, 0,  0, 1, 1, 0,  0, 0,  1, 2, 0};
    vecs[1]  = '{  20,  5, 0,  0, 1, 1, 1,  0, 0,  1, 7, 0};
    vecs[2]  = '{  24,  6, 0,  0, 1, 1, 1,  0, 0,  0, 7, 0};
    vecs[3]  = '{  40, 10, 0,  1, 1, 0, 1,  0, 0,  0, 7, 0};
    vecs[4]  = '{  48, 12, 0,  1, 1, 0, 1,  0, 0,  0, 7, 0};
    vecs[5]  = '{  52, 13, 0,  0, 1, 0, 1,  0, 0,  0, 7, 0};
    vecs[6]  = '{  56, 14, 0,  0, 1, 0, 1,  0, 0,  1, 0, 1};
    vecs[7]  = '{  60, 15, 0,  0, 1, 0, 1,  0, 0,  1, 1, 1};
    vecs[8]  = '{  64,  0, 1,  0, 1, 1, 1,  1, 0,  1, 2, 1};
    vecs[9]  = '{ 220,  7, 3,  0, 1, 1, 1,  0, 0,  0, 7, 3};
    vecs[10] = '{ 248, 14, 3,  0, 1, 0, 1,  0, 0,  0, 7, 3};
    vecs[11] = '{ 256,  0, 4,  0, 1, 0, 1,  1, 0,  0, 7, 3};
    vecs[12] = '{ 332,  3, 5,  0, 0, 0, 1,  0, 0,  0, 7, 3};
    vecs[13] = '{ 380, 15, 5,  0, 0, 0, 1,  0, 0,  0, 7, 3};
    vecs[14] = '{ 384,  0, 6,  0, 1, 0, 1,  1, 0,  0, 7, 3};
    vecs[15] = '{ 440, 14, 6,  0, 1, 0, 1,  0, 0,  1, 0, 0};
    vecs[16] = '{ 444, 15, 6,  0, 1, 0, 1,  0, 0,  1, 1, 0};
    vecs[17] = '{ 448,  0, 0,  0, 1, 1, 1,  1, 1,  1, 2, 0};

    rst_a = 1'b0;
    rst_b = 1'b0;
    en_a  = 1'b1;
    en_b  = 1'b1;

    // ---- reset values on both instances
    #12;
    check_val("A rst hcount",      int'(vid_a.hcount),      0);
    check_val("A rst vcount",      int'(vid_a.vcount),      0);
    check_val("A rst hsync",       int'(vid_a.hsync),       1);
    check_val("A rst vsync",       int'(vid_a.vsync),       1);
    check_val("A rst blank_n",     int'(vid_a.vga_blank_n), 0);
    check_val("A rst vga_clk",     int'(vid_a.vga_clk),     0);
    check_val("A rst fetch_valid", int'(vid_a.fetch_valid), 0);
    check_val("A rst line_start",  int'(vid_a.line_start),  0);
    check_val("A rst frame_start", int'(vid_a.frame_start), 0);
    check_val("B rst hsync",       int'(vid_b.hsync),       0);
    check_val("B rst vsync",       int'(vid_b.vsync),       1);
    check_val("B rst fetch_x",     int'(vid_b.fetch_x),     0);
    check_val("B rst fetch_y",     int'(vid_b.fetch_y),     0);

    // ---- dut_a: scan line 0 and the start of line 1 at default timing
    @(negedge clk);
    rst_a = 1'b1;
    hc_err = 0; vc_err = 0; hs_err = 0; vs_err = 0; bl_err = 0;
    fv_err = 0; fxy_err = 0; ls_err = 0; fs_err = 0; vclk_err = 0;
    low_cnt = 0; first_low = -1; last_low = -1; blank_cnt0 = 0;
    for (int n = 1; n <= 805; n++) begin
      tick(1);
      if (vid_a.vga_clk !== 1'b0) vclk_err++;
      tick(1);
      if (vid_a.vga_clk !== 1'b1) vclk_err++;
      h = n % 800;
      v = n / 800;
      hse = (h >= 656 && h < 752) ? 0 : 1;
      ble = (h < 640) ? 1 : 0;
      lse = (h == 0) ? 1 : 0;
      fxe = h + 2;
      fye = v;
      if (fxe >= 800) begin
        fxe = fxe - 800;
        fye = v + 1;
      end
      fve = (fxe < 640 && fye < 480) ? 1 : 0;
      if (int'(vid_a.hcount) != h)          hc_err++;
      if (int'(vid_a.vcount) != v)          vc_err++;
      if (int'(vid_a.hsync) != hse)         hs_err++;
      if (vid_a.vsync !== 1'b1)             vs_err++;
      if (int'(vid_a.vga_blank_n) != ble)   bl_err++;
      if (int'(vid_a.line_start) != lse)    ls_err++;
      if (vid_a.frame_start !== 1'b0)       fs_err++;
      if (int'(vid_a.fetch_valid) != fve)   fv_err++;
      if (fve == 1 && (int'(vid_a.fetch_x) != fxe || int'(vid_a.fetch_y) != fye)) fxy_err++;
      if (v == 0 && vid_a.hsync == 1'b0) begin
        low_cnt++;
        if (first_low < 0) first_low = h;
        last_low = h;
      end
      if (v == 0 && vid_a.vga_blank_n == 1'b1) blank_cnt0++;
    end
    check_val("A scan hcount errors",      hc_err,   0);
    check_val("A scan vcount errors",      vc_err,   0);
    check_val("A scan hsync errors",       hs_err,   0);
    check_val("A scan vsync errors",       vs_err,   0);
    check_val("A scan blank_n errors",     bl_err,   0);
    check_val("A scan line_start errors",  ls_err,   0);
    check_val("A scan frame_start errors", fs_err,   0);
    check_val("A scan fetch_valid errors", fv_err,   0);
    check_val("A scan fetch_xy errors",    fxy_err,  0);
    check_val("A scan vga_clk errors",     vclk_err, 0);
    check_val("A hsync low count",         low_cnt,  96);
    check_val("A hsync first low",         first_low, 656);
    check_val("A hsync last low",          last_low, 751);
    // Positions 1..639 of line 0 (position 0 precedes the first sample).
    check_val("A line0 blank_n count",     blank_cnt0, 639);

    // ---- dut_a: asynchronous reset at hcount=300 of line 1
    tick(2 * (1100 - 805));
    check_val("A pre-reset hcount", int'(vid_a.hcount), 300);
    check_val("A pre-reset vcount", int'(vid_a.vcount), 1);
    #3;
    rst_a = 1'b0;
    #1;
    check_val("A async rst hcount",      int'(vid_a.hcount),      0);
    check_val("A async rst vcount",      int'(vid_a.vcount),      0);
    check_val("A async rst hsync",       int'(vid_a.hsync),       1);
    check_val("A async rst vsync",       int'(vid_a.vsync),       1);
    check_val("A async rst blank_n",     int'(vid_a.vga_blank_n), 0);
    check_val("A async rst vga_clk",     int'(vid_a.vga_clk),     0);
    check_val("A async rst fetch_valid", int'(vid_a.fetch_valid), 0);
    check_val("A async rst fetch_x",     int'(vid_a.fetch_x),     0);
    check_val("A async rst fetch_y",     int'(vid_a.fetch_y),     0);
    @(negedge clk);
    rst_a = 1'b1;
    tick(1);
    check_val("A restart hcount edge1", int'(vid_a.hcount), 0);
    tick(1);
    check_val("A restart hcount edge2", int'(vid_a.hcount), 1);
    check_val("A restart vcount edge2", int'(vid_a.vcount), 0);

    // ---- dut_b: table-driven walk through one full small frame
    @(negedge clk);
    rst_b  = 1'b1;
    edge_b = 0;
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].edge_no);
      checkOutput(vecs[i], i);
    end

    // ---- dut_b: one whole frame measured between frame_start pulses
    blank_cnt = int'(vid_b.vga_blank_n);
    hs_cnt    = int'(vid_b.hsync);
    vs_cnt    = (vid_b.vsync == 1'b0) ? 1 : 0;
    ls_cnt    = int'(vid_b.line_start);
    frame_clks = 0;
    seen = 0;
    for (int c = 1; c <= 600 && seen == 0; c++) begin
      tick(1);
      if (vid_b.frame_start == 1'b1) begin
        seen = 1;
        frame_clks = c;
      end else begin
        blank_cnt += int'(vid_b.vga_blank_n);
        hs_cnt    += int'(vid_b.hsync);
        vs_cnt    += (vid_b.vsync == 1'b0) ? 1 : 0;
        ls_cnt    += int'(vid_b.line_start);
      end
    end
    edge_b += frame_clks;
    check_val("B frame period clks",   frame_clks, 448);
    check_val("B frame blank_n clks",  blank_cnt,  128);
    check_val("B frame hsync hi clks", hs_cnt,     84);
    check_val("B frame vsync lo clks", vs_cnt,     64);
    check_val("B frame line_starts",   ls_cnt,     7);

    // ---- dut_b: en low for 5 clocks mid-line, then resume
    tick(20);
    check_val("B pre-en hcount", int'(vid_b.hcount), 5);
    en_b = 1'b0;
    tick(1);
    check_val("B en-low hcount",      int'(vid_b.hcount),      0);
    check_val("B en-low vcount",      int'(vid_b.vcount),      0);
    check_val("B en-low hsync",       int'(vid_b.hsync),       0);
    check_val("B en-low vsync",       int'(vid_b.vsync),       1);
    check_val("B en-low blank_n",     int'(vid_b.vga_blank_n), 0);
    check_val("B en-low fetch_valid", int'(vid_b.fetch_valid), 0);
    check_val("B en-low vga_clk",     int'(vid_b.vga_clk),     0);
    tick(4);
    check_val("B en-low5 hcount",     int'(vid_b.hcount),      0);
    check_val("B en-low5 line_start", int'(vid_b.line_start),  0);
    check_val("B en-low5 vga_clk",    int'(vid_b.vga_clk),     0);
    en_b = 1'b1;
    frame_clks = 0;
    seen = 0;
    for (int e = 1; e <= 1000 && seen == 0; e++) begin
      tick(1);
      if (e == 3) check_val("B resume hcount edge3", int'(vid_b.hcount), 0);
      if (e == 4) check_val("B resume hcount edge4", int'(vid_b.hcount), 1);
      if (vid_b.frame_start == 1'b1) begin
        seen = 1;
        frame_clks = e;
      end
    end
    check_val("B resume frame_start clks", frame_clks, 448);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
